// File: rtl/mem_arbiter_pkg.sv
// Shared control types for the memory arbiter and the inner memory handler.
package control_signal_types;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } memrw_t;

    typedef enum logic [1:0] {
        RW_BYTE = 2'd0,
        RW_HALF = 2'd1,
        RW_WORD = 2'd2
    } rw_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port link between the arbiter (user side) and the memory handler.
interface inner_memory_if;
    import control_signal_types::*;

    memrw_t      MemRW;
    rw_type_t    RWType;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport user    (output MemRW, RWType, addr_out, data_out, input  data_in);
    modport handler (input  MemRW, RWType, addr_out, data_out, output data_in);
    modport master  (output MemRW, RWType, addr_out, data_out, input  data_in);
    modport slave   (input  MemRW, RWType, addr_out, data_out, output data_in);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one
// memory handler. Data wins by default, but an instruction request that has
// waited through STARVE_LIMIT consecutive data grants is served next.
//
// state  | meaning
// IDLE   | no access in flight; grants are decided combinationally
// BUSY_I | fetch access presented to the handler, waiting for mem_ready
// BUSY_D | data access presented to the handler, waiting for mem_ready
module mem_arbiter
    import control_signal_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           i_req,
    input  logic [31:0]    i_addr,
    input  logic           i_flush,
    output logic           i_gnt,
    output logic           i_rvalid,
    output logic [31:0]    i_rdata,

    input  logic           d_req,
    input  memrw_t         d_memrw,
    input  rw_type_t       d_rwtype,
    input  logic [31:0]    d_addr,
    input  logic [31:0]    d_wdata,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [31:0]    d_rdata,

    inner_memory_if.user   mem,
    output logic           mem_valid,
    input  logic           mem_ready
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    memrw_t           lat_memrw;
    rw_type_t         lat_rwtype;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    // remembers a flush seen earlier in the current fetch so the response is dropped
    logic             flushed;
    logic             grant_d;
    logic             grant_i;

    // Grant decision: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (rst_n && (state == IDLE)) begin
            grant_d = d_req && ((starve_cnt < CNT_MAX) || !i_req);
            grant_i = i_req && !grant_d;
        end
    end

    assign i_gnt        = grant_i;
    assign d_gnt        = grant_d;
    assign mem.MemRW    = lat_memrw;
    assign mem.RWType   = lat_rwtype;
    assign mem.addr_out = lat_addr;
    assign mem.data_out = lat_wdata;

    // Arbiter FSM, request latching, starvation counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_valid  <= 1'b0;
            lat_memrw  <= MEM_READ;
            lat_rwtype <= RW_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            flushed    <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        lat_memrw  <= d_memrw;
                        lat_rwtype <= d_rwtype;
                        lat_addr   <= d_addr;
                        lat_wdata  <= d_wdata;
                        mem_valid  <= 1'b1;
                        state      <= BUSY_D;
                        if (i_req) begin
                            if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (grant_i) begin
                        lat_memrw  <= MEM_READ;
                        lat_rwtype <= RW_WORD;
                        lat_addr   <= i_addr;
                        lat_wdata  <= '0;
                        mem_valid  <= 1'b1;
                        flushed    <= 1'b0;
                        starve_cnt <= '0;
                        state      <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        i_rdata   <= mem.data_in;
                        i_rvalid  <= !(flushed || i_flush);
                        flushed   <= 1'b0;
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (i_flush) begin
                        flushed <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        d_rdata   <= mem.data_in;
                        d_rvalid  <= 1'b1;
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;
    import control_signal_types::*;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    memrw_t      d_memrw = MEM_READ;
    rw_type_t    d_rwtype = RW_WORD;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b1;

    inner_memory_if mif ();

    // memory handler model: read data is a fixed function of the address
    assign mif.data_in = mif.addr_out ^ KEY;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_memrw  (d_memrw),
        .d_rwtype (d_rwtype),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem      (mif.user),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge and score any response that appeared
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (i_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_d_rvalid", {31'b0, d_rvalid}, {31'b0, e.is_d});
                chk("resp_i_rvalid", {31'b0, i_rvalid}, {31'b0, !e.is_d});
                chk("resp_rdata", e.is_d ? d_rdata : i_rdata, e.data);
            end
        end
    endtask

    // one arbitrated access with mem_ready high: check grant, expect response
    task automatic arb_step(input string tag, input logic exp_d);
        #1;
        chk({tag, "_d_gnt"}, {31'b0, d_gnt}, {31'b0, exp_d});
        chk({tag, "_i_gnt"}, {31'b0, i_gnt}, {31'b0, !exp_d});
        if (exp_d) sb.push_back('{1'b1, d_addr ^ KEY});
        else       sb.push_back('{1'b0, i_addr ^ KEY});
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: no grants while rst_n is low, everything cleared
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        tick();
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_addr_out", mif.addr_out, 32'd0);
        chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
        tick();

        // single fetch: gnt at 0, mem_valid at 1, rvalid at 2
        i_req  = 1'b1;
        i_addr = 32'h100;
        #1;
        chk("fetch_i_gnt", {31'b0, i_gnt}, 32'd1);
        chk("fetch_d_gnt", {31'b0, d_gnt}, 32'd0);
        sb.push_back('{1'b0, 32'h100 ^ KEY});
        tick();
        i_req = 1'b0;
        chk("fetch_mem_valid", {31'b0, mem_valid}, 32'd1);
        chk("fetch_addr_out", mif.addr_out, 32'h100);
        chk("fetch_memrw", {31'b0, mif.MemRW}, {31'b0, MEM_READ});
        chk("fetch_rwtype", {30'b0, mif.RWType}, {30'b0, RW_WORD});
        chk("fetch_data_out", mif.data_out, 32'd0);
        #1;
        chk("fetch_busy_gnt", {31'b0, i_gnt}, 32'd0);
        tick();
        chk("fetch_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        chk("fetch_idle_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("fetch_hold_addr", mif.addr_out, 32'h100);
        tick();
        chk("fetch_rvalid_pulse", {31'b0, i_rvalid}, 32'd0);
        chk("fetch_rdata_hold", i_rdata, 32'h100 ^ KEY);

        // contention: D,D,D,D,I,D,D,D,D,I
        i_addr  = 32'h300;
        d_addr  = 32'h3000;
        d_memrw = MEM_READ;
        i_req   = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            arb_step("contention", (k % 5) != 4);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();

        // wait states on a data write: outputs stable over 4 busy cycles
        d_req     = 1'b1;
        d_memrw   = MEM_WRITE;
        d_rwtype  = RW_WORD;
        d_addr    = 32'h2000;
        d_wdata   = 32'hDEADBEEF;
        mem_ready = 1'b0;
        #1;
        chk("ws_d_gnt", {31'b0, d_gnt}, 32'd1);
        sb.push_back('{1'b1, 32'h2000 ^ KEY});
        tick();
        d_req   = 1'b0;
        d_addr  = 32'h1111_1111;
        d_wdata = 32'h2222_2222;
        d_memrw = MEM_READ;
        for (int k = 0; k < 4; k++) begin
            chk("ws_mem_valid", {31'b0, mem_valid}, 32'd1);
            chk("ws_addr_out", mif.addr_out, 32'h2000);
            chk("ws_data_out", mif.data_out, 32'hDEADBEEF);
            chk("ws_memrw", {31'b0, mif.MemRW}, {31'b0, MEM_WRITE});
            chk("ws_d_rvalid", {31'b0, d_rvalid}, 32'd0);
            if (k == 3) mem_ready = 1'b1;
            tick();
        end
        chk("ws_d_rvalid_done", {31'b0, d_rvalid}, 32'd1);
        tick();
        chk("ws_d_rvalid_once", {31'b0, d_rvalid}, 32'd0);
        chk("ws_d_rdata_hold", d_rdata, 32'h2000 ^ KEY);

        // flush during BUSY_I while waiting: completes, no rvalid
        i_req     = 1'b1;
        i_addr    = 32'h400;
        mem_ready = 1'b0;
        #1;
        chk("flush_i_gnt", {31'b0, i_gnt}, 32'd1);
        tick();
        i_req   = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush   = 1'b0;
        mem_ready = 1'b1;
        chk("flush_mem_valid_busy", {31'b0, mem_valid}, 32'd1);
        tick();
        chk("flush_no_rvalid", {31'b0, i_rvalid}, 32'd0);
        chk("flush_completed", {31'b0, mem_valid}, 32'd0);

        // flush in the mem_ready cycle also suppresses the response
        i_req  = 1'b1;
        i_addr = 32'h480;
        #1;
        chk("flush2_i_gnt", {31'b0, i_gnt}, 32'd1);
        tick();
        i_req   = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush2_no_rvalid", {31'b0, i_rvalid}, 32'd0);

        // flush together with a request in IDLE is still granted and answered
        i_req   = 1'b1;
        i_flush = 1'b1;
        i_addr  = 32'h500;
        #1;
        chk("flush_idle_i_gnt", {31'b0, i_gnt}, 32'd1);
        sb.push_back('{1'b0, 32'h500 ^ KEY});
        tick();
        i_req   = 1'b0;
        i_flush = 1'b0;
        tick();
        chk("after_flush_i_rvalid", {31'b0, i_rvalid}, 32'd1);

        // flush has no effect on the data port
        i_flush = 1'b1;
        d_req   = 1'b1;
        d_addr  = 32'h5000;
        #1;
        chk("flush_data_d_gnt", {31'b0, d_gnt}, 32'd1);
        sb.push_back('{1'b1, 32'h5000 ^ KEY});
        tick();
        d_req = 1'b0;
        tick();
        chk("flush_data_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        i_flush = 1'b0;
        tick();

        // reset during BUSY_D after building up starvation count
        i_addr = 32'h600;
        d_addr = 32'h6000;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 3; k++) arb_step("prereset", 1'b1);
        mem_ready = 1'b0;
        #1;
        chk("midrst_d_gnt", {31'b0, d_gnt}, 32'd1);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        chk("midrst_busy", {31'b0, mem_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("midrst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("midrst_state", {30'b0, dut.state}, {30'b0, IDLE});
        chk("midrst_starve", 32'(dut.starve_cnt), 32'd0);
        mem_ready = 1'b1;
        tick();
        chk("midrst_no_late_rvalid", {31'b0, d_rvalid}, 32'd0);

        // cleared starvation count: full D,D,D,D,I pattern again
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 5; k++) arb_step("postreset", k != 4);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
